// File: rtl/cache_sa_param.sv
// Parametrised set-associative, write-through, write-allocate cache with NMRU
// replacement, whole-cache flush and per-request hit/miss event pulses.
module cache_sa_param #(
  parameter int SETS       = 32,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid,
  output logic        o_busy,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [3:0]  i_req_mask,
  input  logic [31:0] i_req_wdata,
  output logic [31:0] o_res_rdata,
  input  logic        i_flush,
  output logic        o_hit,
  output logic        o_miss
);

  localparam int OB = $clog2(LINE_WORDS) + 2;
  localparam int SB = $clog2(SETS);
  localparam int TB = 32 - OB - SB;
  localparam int KB = $clog2(LINE_WORDS);
  localparam int WB = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [KB-1:0] LAST_K = KB'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [TB-1:0]   r_tag   [SETS][WAYS];
  logic [31:0]     r_data  [SETS][WAYS][LINE_WORDS];
  logic [WAYS-1:0] r_valid [SETS];
  logic [WB-1:0]   r_mru   [SETS];

  logic [KB-1:0] r_k;
  logic [WB-1:0] r_way;
  logic          r_is_write;
  logic [31:0]   r_addr;
  logic [3:0]    r_mask;
  logic [31:0]   r_wdata;

  logic [TB-1:0]   w_req_tag;
  logic [SB-1:0]   w_req_idx;
  logic [KB-1:0]   w_req_word;
  logic [SB-1:0]   w_cur_idx;
  logic [KB-1:0]   w_cur_word;
  logic            w_req;
  logic [WAYS-1:0] w_hit_vec;
  logic            w_hit;
  logic [WB-1:0]   w_hit_way;
  logic [WB-1:0]   w_victim;
  logic [31:0]     w_hit_word;
  logic [31:0]     w_cur_data;
  logic [31:0]     w_merged;
  logic            w_unused;

  assign w_unused   = &{1'b0, i_req_addr[1:0]};
  assign w_req      = i_req_ren | i_req_wen;
  assign w_req_tag  = i_req_addr[31:OB+SB];
  assign w_req_idx  = i_req_addr[OB+SB-1:OB];
  assign w_req_word = i_req_addr[OB-1:2];
  assign w_cur_idx  = r_addr[OB+SB-1:OB];
  assign w_cur_word = r_addr[OB-1:2];

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    w_hit_vec = '0;
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = r_valid[w_req_idx][w] && (r_tag[w_req_idx][w] == w_req_tag);
      if (w_hit_vec[w]) begin
        w_hit     = 1'b1;
        w_hit_way = WB'(w);
      end
    end
  end

  // Lowest-index invalid way wins; otherwise the way after the most recently used one.
  always_comb begin
    w_victim = (WAYS == 1) ? '0 : r_mru[w_req_idx] + 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_req_idx][w]) w_victim = WB'(w);
    end
  end

  assign w_hit_word = r_data[w_req_idx][w_hit_way][w_req_word];
  assign w_cur_data = r_data[w_cur_idx][r_way][w_cur_word];
  assign w_merged   = byte_merge(w_cur_data, r_wdata, r_mask);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_busy      = 1'b0;
    o_hit       = 1'b0;
    o_miss      = 1'b0;
    o_mem_ren   = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_res_rdata = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            o_hit = 1'b1;
            if (i_req_wen) begin
              o_busy = 1'b1;
              w_next = S_WRITE;
            end else begin
              o_res_rdata = w_hit_word;
            end
          end else begin
            o_miss = 1'b1;
            o_busy = 1'b1;
            w_next = S_FILL_REQ;
          end
        end
      end
      S_FILL_REQ: begin
        o_busy     = 1'b1;
        o_mem_ren  = 1'b1;
        o_mem_addr = {r_addr[31:OB], r_k, 2'b00};
        if (i_mem_ready) w_next = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        o_busy = 1'b1;
        if (i_mem_valid) begin
          if (r_k == LAST_K) w_next = r_is_write ? S_WRITE : S_DONE;
          else               w_next = S_FILL_REQ;
        end
      end
      S_WRITE: begin
        o_busy      = 1'b1;
        o_mem_wen   = 1'b1;
        o_mem_addr  = r_addr;
        o_mem_wdata = w_merged;
        if (i_mem_ready) w_next = S_DONE;
      end
      S_DONE: begin
        o_res_rdata = w_cur_data;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_mru[s]   <= '0;
      end
      r_k        <= '0;
      r_way      <= '0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_mask     <= '0;
      r_wdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr     <= {i_req_addr[31:2], 2'b00};
            r_mask     <= i_req_mask;
            r_wdata    <= i_req_wdata;
            r_is_write <= i_req_wen;
            if (w_hit) begin
              r_way <= w_hit_way;
              if (i_req_ren) r_mru[w_req_idx] <= w_hit_way;
            end else begin
              r_way <= w_victim;
              r_k   <= '0;
              r_valid[w_req_idx][w_victim] <= 1'b0;
            end
          end else if (i_flush) begin
            for (int s = 0; s < SETS; s++) begin
              r_valid[s] <= '0;
              r_mru[s]   <= '0;
            end
          end
        end
        S_FILL_WAIT: begin
          if (i_mem_valid) begin
            if (r_k == LAST_K) begin
              r_valid[w_cur_idx][r_way] <= 1'b1;
              r_mru[w_cur_idx]          <= r_way;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (i_mem_ready) r_mru[w_cur_idx] <= r_way;
        end
        default: ;
      endcase
    end
  end

  // NOTE: data and tag storage has no reset; valid bits alone decide whether a line is usable.
  always_ff @(posedge i_clk) begin
    if (r_state == S_FILL_WAIT && i_mem_valid) begin
      r_data[w_cur_idx][r_way][r_k] <= i_mem_rdata;
      if (r_k == LAST_K) r_tag[w_cur_idx][r_way] <= r_addr[31:OB+SB];
    end
    if (r_state == S_WRITE && i_mem_ready) begin
      r_data[w_cur_idx][r_way][w_cur_word] <= w_merged;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && r_state == S_IDLE && w_req) assert ($onehot0(w_hit_vec));
  end

endmodule

// File: tb/tb_cache_sa_param.sv
// Self-checking bench for cache_sa_param: directed scenarios plus random traffic,
// scored against a line-level reference model through an expected-event queue.
module tb_cache_sa_param;

  localparam int SETS       = 32;
  localparam int WAYS       = 2;
  localparam int LINE_WORDS = 4;
  localparam int OB         = $clog2(LINE_WORDS) + 2;
  localparam int SB         = $clog2(SETS);

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_mem_ready = 1'b0;
  logic [31:0] o_mem_addr;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata = '0;
  logic        i_mem_valid = 1'b0;
  logic        o_busy;
  logic [31:0] i_req_addr = '0;
  logic        i_req_ren = 1'b0;
  logic        i_req_wen = 1'b0;
  logic [3:0]  i_req_mask = '0;
  logic [31:0] i_req_wdata = '0;
  logic [31:0] o_res_rdata;
  logic        i_flush = 1'b0;
  logic        o_hit;
  logic        o_miss;

  cache_sa_param #(.SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LINE_WORDS)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mem_ready(i_mem_ready),
    .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_valid(i_mem_valid),
    .o_busy(o_busy), .i_req_addr(i_req_addr), .i_req_ren(i_req_ren),
    .i_req_wen(i_req_wen), .i_req_mask(i_req_mask), .i_req_wdata(i_req_wdata),
    .o_res_rdata(o_res_rdata), .i_flush(i_flush), .o_hit(o_hit), .o_miss(o_miss)
  );

  always #5 i_clk = ~i_clk;

  typedef enum int {EV_HIT, EV_MISS, EV_MRD, EV_MWR, EV_RES} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  logic [31:0] dut_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  bit          m_valid [SETS][WAYS];
  logic [31:0] m_tag   [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS][LINE_WORDS];
  int          m_mru   [SETS];

  bit          mon_en = 1'b1;
  bit          pending = 1'b0;
  logic [31:0] paddr;
  int          delay;
  int          rd_words = 0;
  int          rd_acc = 0;
  logic [31:0] last_wr_data = '0;
  logic        last_hit;
  logic [31:0] last_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_ev(input ev_kind_t k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s addr %h data %h, required none", k.name(), a, d);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.addr !== a || e.data !== d) begin
      n_fail++;
      $display("FAIL event_%s: got %s addr %h data %h, required %s addr %h data %h",
               e.kind.name(), k.name(), a, d, e.kind.name(), e.addr, e.data);
    end
  endtask

  function automatic void push_ev(input ev_kind_t k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  function automatic logic [31:0] dut_rd(input logic [31:0] a);
    return dut_mem.exists(a) ? dut_mem[a] : default_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : default_word(a);
  endfunction

  function automatic void preload(input logic [31:0] a, input logic [31:0] d);
    dut_mem[a] = d;
    ref_mem[a] = d;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_mru[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  // Predicts every observable event of one request and updates the model state.
  function automatic void model_request(input bit is_wr, input logic [31:0] addr,
                                        input logic [3:0] mask, input logic [31:0] wdata,
                                        output bit hit);
    int          set, word, way;
    logic [31:0] tag, base, waddr, merged;
    set   = int'((addr >> OB) % SETS);
    word  = int'((addr >> 2) % LINE_WORDS);
    tag   = addr >> (OB + SB);
    base  = addr & ~32'(LINE_WORDS * 4 - 1);
    waddr = addr & ~32'h3;
    way   = -1;
    for (int w = 0; w < WAYS; w++) if (m_valid[set][w] && m_tag[set][w] == tag) way = w;
    hit = (way >= 0);
    if (hit) begin
      push_ev(EV_HIT, 0, 0);
    end else begin
      push_ev(EV_MISS, 0, 0);
      for (int w = 0; w < WAYS; w++) if (!m_valid[set][w] && way < 0) way = w;
      if (way < 0) way = (m_mru[set] + 1) % WAYS;
      for (int k = 0; k < LINE_WORDS; k++) begin
        push_ev(EV_MRD, base + 32'(4 * k), 0);
        m_data[set][way][k] = ref_rd(base + 32'(4 * k));
      end
      m_valid[set][way] = 1'b1;
      m_tag[set][way]   = tag;
    end
    if (is_wr) begin
      merged = byte_merge(m_data[set][way][word], wdata, mask);
      push_ev(EV_MWR, waddr, merged);
      m_data[set][way][word] = merged;
      ref_mem[waddr] = merged;
    end
    m_mru[set] = way;
    push_ev(EV_RES, waddr, m_data[set][way][word]);
  endfunction

  // Memory responder and output monitor.
  initial begin
    forever begin
      @(negedge i_clk);
      i_mem_valid = 1'b0;
      i_mem_ready = 1'b0;
      if (!i_rst_n) begin
        pending = 1'b0;
        continue;
      end
      if (mon_en && o_hit)  check_ev(EV_HIT, 0, 0);
      if (mon_en && o_miss) check_ev(EV_MISS, 0, 0);
      if (pending) begin
        if (delay == 0) begin
          i_mem_valid = 1'b1;
          i_mem_rdata = dut_rd(paddr);
          pending = 1'b0;
          rd_words++;
        end else begin
          delay--;
        end
      end else if (o_mem_ren) begin
        if ($urandom_range(0, 3) != 0) begin
          i_mem_ready = 1'b1;
          pending = 1'b1;
          paddr = o_mem_addr;
          delay = $urandom_range(0, 2);
          rd_acc++;
          if (mon_en) check_ev(EV_MRD, o_mem_addr, 0);
        end
      end else if (o_mem_wen) begin
        if ($urandom_range(0, 3) != 0) begin
          i_mem_ready = 1'b1;
          dut_mem[o_mem_addr] = o_mem_wdata;
          last_wr_data = o_mem_wdata;
          if (mon_en) check_ev(EV_MWR, o_mem_addr, o_mem_wdata);
        end
      end
      if (mon_en && (i_req_ren || i_req_wen) && !o_busy)
        check_ev(EV_RES, {i_req_addr[31:2], 2'b00}, o_res_rdata);
    end
  end

  task automatic do_req(input bit is_wr, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] wdata, input bit flush_mid);
    bit exp_hit, done, flushed;
    int cyc;
    model_request(is_wr, addr, mask, wdata, exp_hit);
    @(posedge i_clk); #1;
    i_req_addr  = addr;
    i_req_ren   = !is_wr;
    i_req_wen   = is_wr;
    i_req_mask  = mask;
    i_req_wdata = wdata;
    cyc = 0;
    done = 1'b0;
    flushed = 1'b0;
    while (!done && cyc < 300) begin
      @(negedge i_clk);
      cyc++;
      if (i_flush) i_flush = 1'b0;
      if (cyc == 1) last_hit = o_hit;
      if (flush_mid && !flushed && o_mem_ren) begin
        i_flush = 1'b1;
        flushed = 1'b1;
      end
      if (!o_busy) done = 1'b1;
    end
    last_res = o_res_rdata;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_timeout: addr %h still busy after %0d cycles, required completion", addr, cyc);
    end else if (exp_hit && !is_wr) begin
      check("read_hit_latency", cyc, 1);
    end
    @(posedge i_clk); #1;
    i_req_ren = 1'b0;
    i_req_wen = 1'b0;
    i_flush   = 1'b0;
  endtask

  task automatic do_flush();
    @(posedge i_clk); #1;
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    model_clear();
  endtask

  task automatic apply_reset();
    i_rst_n   = 1'b0;
    i_req_ren = 1'b0;
    i_req_wen = 1'b0;
    i_flush   = 1'b0;
    @(negedge i_clk);
    check("reset_ctrl", {27'b0, o_busy, o_hit, o_miss, o_mem_ren, o_mem_wen}, 32'h0);
    check("reset_data", o_mem_addr | o_mem_wdata | o_res_rdata, 32'h0);
    exp_q.delete();
    model_clear();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    int rd0, acc0, cyc;
    logic [31:0] a;
    #2;
    apply_reset();

    preload(32'h100, 32'h11);
    preload(32'h104, 32'h22);
    preload(32'h108, 32'h33);
    preload(32'h10C, 32'h44);
    do_req(0, 32'h100, 4'h0, 32'h0, 0);
    check("first_read_miss", {31'b0, last_hit}, 32'h0);
    check("first_read_data", last_res, 32'h11);
    do_req(0, 32'h108, 4'h0, 32'h0, 0);
    check("reread_hit", {31'b0, last_hit}, 32'h1);
    check("reread_data", last_res, 32'h33);

    do_req(1, 32'h104, 4'b0011, 32'hAABBCCDD, 0);
    check("write_hit_wdata", last_wr_data, 32'h0000CCDD);
    do_req(0, 32'h104, 4'h0, 32'h0, 0);
    check("read_after_write", last_res, 32'h0000CCDD);

    do_flush();
    do_req(0, 32'h4000, 4'h0, 32'h0, 0);
    do_req(0, 32'h4200, 4'h0, 32'h0, 0);
    do_req(0, 32'h4000, 4'h0, 32'h0, 0);
    check("nmru_a_hit", {31'b0, last_hit}, 32'h1);
    do_req(0, 32'h4400, 4'h0, 32'h0, 0);
    do_req(0, 32'h4000, 4'h0, 32'h0, 0);
    check("nmru_a_kept", {31'b0, last_hit}, 32'h1);
    do_req(0, 32'h4200, 4'h0, 32'h0, 0);
    check("nmru_b_evicted", {31'b0, last_hit}, 32'h0);

    preload(32'h2000, 32'h12345678);
    do_req(1, 32'h2000, 4'b1000, 32'h7F000000, 0);
    check("write_miss_merge", last_wr_data, 32'h7F345678);
    check("write_miss_res", last_res, 32'h7F345678);

    rd0 = rd_words;
    mon_en = 1'b0;
    @(posedge i_clk); #1;
    i_req_addr = 32'h3000;
    i_req_ren  = 1'b1;
    cyc = 0;
    while (rd_words < rd0 + 2 && cyc < 300) begin
      @(posedge i_clk);
      cyc++;
    end
    check("midfill_words_before_reset", 32'(rd_words - rd0), 32'd2);
    #2;
    apply_reset();
    mon_en = 1'b1;
    acc0 = rd_acc;
    do_req(0, 32'h3000, 4'h0, 32'h0, 0);
    check("refill_after_reset", 32'(rd_acc - acc0), 32'(LINE_WORDS));
    check("refill_after_reset_miss", {31'b0, last_hit}, 32'h0);

    do_req(0, 32'h5000, 4'h0, 32'h0, 0);
    do_req(0, 32'h5010, 4'h0, 32'h0, 0);
    do_flush();
    do_req(0, 32'h5000, 4'h0, 32'h0, 0);
    check("flush_line0_miss", {31'b0, last_hit}, 32'h0);
    do_req(0, 32'h5010, 4'h0, 32'h0, 0);
    check("flush_line1_miss", {31'b0, last_hit}, 32'h0);
    do_req(0, 32'h6000, 4'h0, 32'h0, 1);
    do_req(0, 32'h6000, 4'h0, 32'h0, 0);
    check("flush_in_fill_ignored", {31'b0, last_hit}, 32'h1);

    for (int i = 0; i < 300; i++) begin
      a = ((32'($urandom_range(0, 5)) + 32'h40) << (OB + SB))
        | (32'($urandom_range(0, 2)) << OB)
        | (32'($urandom_range(0, LINE_WORDS - 1)) << 2)
        | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) do_flush();
      do_req($urandom_range(0, 9) < 4, a, 4'($urandom_range(0, 15)), $urandom, 0);
    end

    repeat (3) @(posedge i_clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_sa_param.md
Name: cache_sa_param

Overview:
- Parametrised set-associative, write-through, write-allocate cache. Successor to the fixed 1 KiB 2-way cache.
- Sits between a hart pipeline stage (IF or MEM) and the word-granular memory interface. One instance serves as I-cache and one as D-cache.
- Generalises sets, ways and line length.
- Adds behaviour the fixed cache lacks: multi-way NMRU replacement, whole-cache flush, and hit/miss event pulses for performance counters.

Parameters:
- SETS, 32, number of sets; power of 2, ≥2.
- WAYS, 2, associativity; power of 2, 1..8.
- LINE_WORDS, 4, 32-bit words per line; power of 2, ≥2.
- Derived values: OB = log2(LINE_WORDS)+2; SB = log2(SETS); TB = 32-OB-SB.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_mem_ready  in  1  memory accepts a request this cycle.
- o_mem_addr  out  32  word-aligned memory address.
- o_mem_ren  out  1  memory read request.
- o_mem_wen  out  1  memory write request.
- o_mem_wdata  out  32  memory write data.
- i_mem_rdata  in  32  memory read data.
- i_mem_valid  in  1  i_mem_rdata valid.
- o_busy  out  1  stall; combinational on miss or write.
- i_req_addr  in  32  request address; [1:0] ignored.
- i_req_ren  in  1  read request.
- i_req_wen  in  1  write request; never asserted together with i_req_ren.
- i_req_mask  in  4  byte enables for writes; ignored on reads.
- i_req_wdata  in  32  write data.
- o_res_rdata  out  32  read data.
- i_flush  in  1  invalidate all lines.
- o_hit  out  1  one-cycle pulse per request that hit.
- o_miss  out  1  one-cycle pulse per request that missed.

Behaviour:
- Reset: asynchronous on i_rst_n low.
  - All valid bits and MRU pointers are cleared; state goes to IDLE.
  - o_mem_ren, o_mem_wen, o_hit and o_miss drive 0; o_busy drives 0.
  - o_mem_addr, o_mem_wdata and o_res_rdata drive 0.
  - Data and tag arrays are not reset.
  - Reset mid-fill or mid-write aborts the operation: partial line is discarded, no valid bit is set.
- Address split: tag = [31:OB+SB], index = [OB+SB-1:OB], word = [OB-1:2].
- Hit: some way w has valid and a matching tag. Tag matches must be one-hot.
- States: IDLE, FILL_REQ, FILL_WAIT, WRITE, DONE.
- IDLE, read hit:
  - o_res_rdata = word, combinational; o_busy = 0; o_hit = 1.
  - MRU[index] <= w at the clock edge.
- IDLE, read miss:
  - o_busy = 1 combinational; o_miss = 1.
  - Request type (ren/wen) is latched.
  - Victim: lowest-index invalid way, else (MRU[index]+1) mod WAYS. With WAYS=1 the victim is always way 0.
  - Fill counter k <= 0; next state FILL_REQ.
- IDLE, write hit: o_busy = 1; o_hit = 1; next state WRITE.
- IDLE, write miss: o_miss = 1; fill as for a read miss, then WRITE.
- The CPU holds i_req_addr, i_req_mask and i_req_wdata stable while o_busy is high; ren/wen may drop.
- FILL_REQ:
  - o_mem_ren = 1; o_mem_addr = {line base, k, 2'b00}.
  - On i_mem_ready go to FILL_WAIT.
- FILL_WAIT:
  - On i_mem_valid, victim word k <= i_mem_rdata.
  - If k < LINE_WORDS-1: k <= k+1, go to FILL_REQ.
  - Else: set tag and valid, MRU <= victim, go to WRITE if the latched op is a write, otherwise DONE.
  - Exactly one outstanding memory request at a time.
- WRITE:
  - o_mem_wen = 1; o_mem_addr = request word address.
  - o_mem_wdata = cached word with the masked bytes replaced by i_req_wdata.
  - On i_mem_ready: the cached word is updated with the same merge, MRU <= way, go to DONE.
  - A mask of 4'b0000 still performs the write (no byte changes).
- DONE: one cycle; o_busy = 0; o_res_rdata = requested word from the now-valid line; return to IDLE.
- o_busy is 1 in FILL_REQ, FILL_WAIT and WRITE.
- Minimum miss latency is 2*LINE_WORDS+1 cycles with zero-wait memory.
- Flush:
  - Honoured only in IDLE with no request: all valid bits and MRU pointers clear at the next edge.
  - Ignored in any other state; the caller holds it until honoured.
  - i_flush together with a request in IDLE is illegal.
- A request whose address crosses no line boundary never touches a second set.

Test Plan:
- Reset, then read 0x0000_0100 with memory returning 0x11,0x22,0x33,0x44 for words 0..3 -> o_miss pulse; four ren at 0x100,0x104,0x108,0x10C; DONE rdata = 0x11; immediate re-read of 0x108 -> same-cycle rdata 0x33, o_busy 0, o_hit 1.
- Write 0xAABBCCDD mask 4'b0011 to cached word 0x104 (holds 0x22) -> o_mem_wen, o_mem_wdata = 0x0000CCDD; subsequent read of 0x104 returns 0x0000CCDD.
- WAYS=2, SETS=32: fill tags A, B into set 0; read A (MRU=way of A); miss on C -> B's way replaced; read A hits; read B misses.
- Write miss to 0x2000 mask 4'b1000 data 0x7F000000 -> 4-word fill, then one write with byte 3 = 0x7F merged onto the fetched word.
- Assert i_rst_n low during FILL_WAIT after 2 words, release, read the same address -> full miss, 4 new memory reads.
- Fill two lines, pulse i_flush in IDLE -> both reads miss afterwards; i_flush asserted in FILL_REQ has no effect on the in-progress fill.
